cache_refill_engine: RTL and testbench

Parametrised line refill engine between the L1 cache and the memory port. It accepts one miss at a time and writes back a dirty victim line if one is present. It then refills the missed line one word per memory handshake, optionally critical-word-first with wrap-around. Each returned word goes to the cache data array with its word index, and the missed word is flagged so the pipeline can restart early.

---
 rtl/cache_refill_engine.sv | 216 +++++++++++++++++++++
 tb/tb_cache_refill_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_engine.sv
// Line refill engine between the L1 cache and the memory port: optional dirty-victim
// writeback followed by a (critical-word-first) line refill, one word per memory handshake.
module cache_refill_engine #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned CRIT_FIRST = 1,
    localparam int unsigned IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             miss_valid,
    output logic             miss_ready,
    input  logic [XLEN-1:0]  miss_addr,
    input  logic             victim_dirty,
    input  logic [XLEN-1:0]  victim_addr,
    output logic [IDX_W-1:0] victim_idx,
    input  logic [XLEN-1:0]  victim_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             mem_ack,
    output logic             refill_valid,
    output logic [IDX_W-1:0] refill_idx,
    output logic [XLEN-1:0]  refill_data,
    output logic             refill_crit,
    output logic             refill_done,
    output logic             busy
);

    localparam int unsigned OFS   = IDX_W + 2;
    localparam int unsigned TAG_W = XLEN - OFS;
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StWb, StRefill} state_e;

    state_e state_q, state_d;

    logic [TAG_W-1:0] base_q, base_d;
    logic [IDX_W-1:0] crit_q, crit_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] victim_idx_q, victim_idx_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
    logic             refill_valid_q, refill_valid_d;
    logic [IDX_W-1:0] refill_idx_q, refill_idx_d;
    logic [XLEN-1:0]  refill_data_q, refill_data_d;
    logic             refill_crit_q, refill_crit_d;
    logic             refill_done_q, refill_done_d;

    logic             beat;
    logic             wb_last;
    logic             refill_last;
    logic [IDX_W-1:0] miss_crit;
    logic [IDX_W-1:0] miss_start;
    logic [IDX_W-1:0] idx_next;

    // Byte-offset bits of both addresses are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{miss_addr[1:0], victim_addr[OFS-1:0]};

    // A beat only completes while a request is outstanding.
    assign beat        = mem_req_q & mem_ack;
    assign wb_last     = (victim_idx_q == LastIdx);
    assign refill_last = (cnt_q == LastIdx);
    assign miss_crit   = miss_addr[OFS-1:2];
    assign miss_start  = (CRIT_FIRST != 0) ? miss_crit : '0;
    assign idx_next    = idx_q + IDX_W'(1);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (miss_valid) begin
                    state_d = victim_dirty ? StWb : StRefill;
                end
            end
            StWb: begin
                if (beat && wb_last) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                if (beat && refill_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered output and datapath next values
    always_comb begin
        base_d         = base_q;
        crit_d         = crit_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        victim_idx_d   = victim_idx_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        refill_valid_d = 1'b0;
        refill_idx_d   = refill_idx_q;
        refill_data_d  = refill_data_q;
        refill_crit_d  = 1'b0;
        refill_done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (miss_valid) begin
                    base_d    = miss_addr[XLEN-1:OFS];
                    crit_d    = miss_crit;
                    idx_d     = miss_start;
                    cnt_d     = '0;
                    mem_req_d = 1'b1;
                    if (victim_dirty) begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = {victim_addr[XLEN-1:OFS], {OFS{1'b0}}};
                        victim_idx_d = '0;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = {miss_addr[XLEN-1:OFS], miss_start, 2'b00};
                    end
                end
            end
            StWb: begin
                if (beat) begin
                    victim_idx_d = victim_idx_q + IDX_W'(1);
                    mem_addr_d   = mem_addr_q + XLEN'(4);
                    if (wb_last) begin
                        // mem_req stays high straight into the refill
                        mem_we_d   = 1'b0;
                        mem_addr_d = {base_q, idx_q, 2'b00};
                    end
                end
            end
            StRefill: begin
                if (beat) begin
                    refill_valid_d = 1'b1;
                    refill_data_d  = mem_rdata;
                    refill_idx_d   = idx_q;
                    refill_crit_d  = (idx_q == crit_q);
                    idx_d          = idx_next;
                    cnt_d          = cnt_q + IDX_W'(1);
                    // Index wraps inside the line, so the address never carries into base.
                    mem_addr_d     = {base_q, idx_next, 2'b00};
                    if (refill_last) begin
                        refill_done_d = 1'b1;
                        mem_req_d     = 1'b0;
                        mem_we_d      = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q         <= '0;
            crit_q         <= '0;
            idx_q          <= '0;
            cnt_q          <= '0;
            victim_idx_q   <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            refill_valid_q <= 1'b0;
            refill_idx_q   <= '0;
            refill_data_q  <= '0;
            refill_crit_q  <= 1'b0;
            refill_done_q  <= 1'b0;
        end else begin
            base_q         <= base_d;
            crit_q         <= crit_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            victim_idx_q   <= victim_idx_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            refill_valid_q <= refill_valid_d;
            refill_idx_q   <= refill_idx_d;
            refill_data_q  <= refill_data_d;
            refill_crit_q  <= refill_crit_d;
            refill_done_q  <= refill_done_d;
        end
    end

    assign miss_ready   = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign mem_wdata    = victim_data;
    assign victim_idx   = victim_idx_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign refill_valid = refill_valid_q;
    assign refill_idx   = refill_idx_q;
    assign refill_data  = refill_data_q;
    assign refill_crit  = refill_crit_q;
    assign refill_done  = refill_done_q;

endmodule

// File: tb/tb_cache_refill_engine.sv
// Directed bench for cache_refill_engine: three instances cover linear (4 words),
// critical-word-first (4 words) and critical-word-first (8 words) configurations.
module tb_cache_refill_engine;

    logic        clk;
    logic        reset;
    logic [31:0] miss_addr;
    logic [31:0] victim_addr;
    logic [31:0] mem_rdata;
    logic        victim_dirty;

    int tests;
    int fails;

    // Instance a: LINE_WORDS=4, CRIT_FIRST=0
    logic        miss_valid_a, miss_ready_a, mem_req_a, mem_we_a, mem_ack_a;
    logic        refill_valid_a, refill_crit_a, refill_done_a, busy_a;
    logic [1:0]  victim_idx_a, refill_idx_a;
    logic [31:0] victim_data_a, mem_addr_a, mem_wdata_a, refill_data_a;
    // Instance b: LINE_WORDS=4, CRIT_FIRST=1
    logic        miss_valid_b, miss_ready_b, mem_req_b, mem_we_b, mem_ack_b;
    logic        refill_valid_b, refill_crit_b, refill_done_b, busy_b;
    logic [1:0]  victim_idx_b, refill_idx_b;
    logic [31:0] victim_data_b, mem_addr_b, mem_wdata_b, refill_data_b;
    // Instance c: LINE_WORDS=8, CRIT_FIRST=1
    logic        miss_valid_c, miss_ready_c, mem_req_c, mem_we_c, mem_ack_c;
    logic        refill_valid_c, refill_crit_c, refill_done_c, busy_c;
    logic [2:0]  victim_idx_c, refill_idx_c;
    logic [31:0] victim_data_c, mem_addr_c, mem_wdata_c, refill_data_c;

    assign victim_data_a = 32'hA0 + {30'd0, victim_idx_a};
    assign victim_data_b = 32'hB0 + {30'd0, victim_idx_b};
    assign victim_data_c = 32'hC0 + {29'd0, victim_idx_c};

    cache_refill_engine #(.XLEN(32), .LINE_WORDS(4), .CRIT_FIRST(0)) dut_a (
        .clk(clk), .reset(reset), .miss_valid(miss_valid_a), .miss_ready(miss_ready_a),
        .miss_addr(miss_addr), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
        .victim_idx(victim_idx_a), .victim_data(victim_data_a), .mem_req(mem_req_a),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack_a), .refill_valid(refill_valid_a),
        .refill_idx(refill_idx_a), .refill_data(refill_data_a), .refill_crit(refill_crit_a),
        .refill_done(refill_done_a), .busy(busy_a)
    );

    cache_refill_engine #(.XLEN(32), .LINE_WORDS(4), .CRIT_FIRST(1)) dut_b (
        .clk(clk), .reset(reset), .miss_valid(miss_valid_b), .miss_ready(miss_ready_b),
        .miss_addr(miss_addr), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
        .victim_idx(victim_idx_b), .victim_data(victim_data_b), .mem_req(mem_req_b),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack_b), .refill_valid(refill_valid_b),
        .refill_idx(refill_idx_b), .refill_data(refill_data_b), .refill_crit(refill_crit_b),
        .refill_done(refill_done_b), .busy(busy_b)
    );

    cache_refill_engine #(.XLEN(32), .LINE_WORDS(8), .CRIT_FIRST(1)) dut_c (
        .clk(clk), .reset(reset), .miss_valid(miss_valid_c), .miss_ready(miss_ready_c),
        .miss_addr(miss_addr), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
        .victim_idx(victim_idx_c), .victim_data(victim_data_c), .mem_req(mem_req_c),
        .mem_we(mem_we_c), .mem_addr(mem_addr_c), .mem_wdata(mem_wdata_c),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack_c), .refill_valid(refill_valid_c),
        .refill_idx(refill_idx_c), .refill_data(refill_data_c), .refill_crit(refill_crit_c),
        .refill_done(refill_done_c), .busy(busy_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        miss_valid_a = 0; miss_valid_b = 0; miss_valid_c = 0;
        mem_ack_a = 0; mem_ack_b = 0; mem_ack_c = 0;
        miss_addr = 0; victim_addr = 0; victim_dirty = 0; mem_rdata = 0;
        step(); step();
        tests++; if (mem_req_a !== 1'b0) begin fails++; $display("FAIL reset mem_req: got %b want 0", mem_req_a); end
        tests++; if (mem_addr_a !== 32'h0) begin fails++; $display("FAIL reset mem_addr: got %h want 0", mem_addr_a); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", busy_a); end
        tests++; if (miss_ready_a !== 1'b1) begin fails++; $display("FAIL reset miss_ready: got %b want 1", miss_ready_a); end
        tests++; if ({refill_valid_a, refill_done_a, refill_crit_a} !== 3'b000) begin fails++; $display("FAIL reset refill flags: got %b want 000", {refill_valid_a, refill_done_a, refill_crit_a}); end
        tests++; if (victim_idx_a !== 2'd0) begin fails++; $display("FAIL reset victim_idx: got %0d want 0", victim_idx_a); end
        tests++; if ({mem_req_b, mem_req_c, mem_we_b, mem_we_c} !== 4'b0) begin fails++; $display("FAIL reset b/c mem_req/we: got %b want 0000", {mem_req_b, mem_req_c, mem_we_b, mem_we_c}); end
        reset = 1'b1;
        step();
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset release busy: got %b want 0", busy_a); end
    endtask

    task automatic test_clean_linear();
        logic [1:0] ei;
        miss_addr = 32'h0000_1234; victim_dirty = 0; miss_valid_a = 1;
        step();
        miss_valid_a = 0;
        tests++; if ({mem_req_a, mem_we_a} !== 2'b10) begin fails++; $display("FAIL linear start req/we: got %b want 10", {mem_req_a, mem_we_a}); end
        tests++; if (mem_addr_a !== 32'h1230) begin fails++; $display("FAIL linear start mem_addr: got %h want 1230", mem_addr_a); end
        tests++; if ({busy_a, miss_ready_a} !== 2'b10) begin fails++; $display("FAIL linear busy/ready: got %b want 10", {busy_a, miss_ready_a}); end
        for (int k = 0; k < 4; k++) begin
            ei = 2'(k);
            mem_ack_a = 1; mem_rdata = 32'h1111_0000 + k;
            step();
            tests++; if (refill_valid_a !== 1'b1) begin fails++; $display("FAIL linear valid beat %0d: got %b want 1", k, refill_valid_a); end
            tests++; if (refill_idx_a !== ei) begin fails++; $display("FAIL linear idx beat %0d: got %0d want %0d", k, refill_idx_a, ei); end
            tests++; if (refill_data_a !== 32'h1111_0000 + k) begin fails++; $display("FAIL linear data beat %0d: got %h want %h", k, refill_data_a, 32'h1111_0000 + k); end
            tests++; if (refill_crit_a !== (k == 1)) begin fails++; $display("FAIL linear crit beat %0d: got %b want %b", k, refill_crit_a, (k == 1)); end
            tests++; if (refill_done_a !== (k == 3)) begin fails++; $display("FAIL linear done beat %0d: got %b want %b", k, refill_done_a, (k == 3)); end
            if (k < 3) begin
                tests++; if (mem_addr_a !== 32'h1230 + 4 * (k + 1)) begin fails++; $display("FAIL linear mem_addr beat %0d: got %h want %h", k, mem_addr_a, 32'h1230 + 4 * (k + 1)); end
            end else begin
                tests++; if ({mem_req_a, miss_ready_a} !== 2'b01) begin fails++; $display("FAIL linear end req/ready: got %b want 01", {mem_req_a, miss_ready_a}); end
            end
        end
        mem_ack_a = 0;
        step();
        tests++; if ({refill_valid_a, refill_done_a} !== 2'b00) begin fails++; $display("FAIL linear after-done flags: got %b want 00", {refill_valid_a, refill_done_a}); end
    endtask

    task automatic test_clean_crit();
        logic [1:0] ei;
        miss_addr = 32'h0000_123C; victim_dirty = 0; miss_valid_b = 1;
        step();
        miss_valid_b = 0;
        tests++; if (mem_addr_b !== 32'h123C) begin fails++; $display("FAIL crit start mem_addr: got %h want 123c", mem_addr_b); end
        for (int k = 0; k < 4; k++) begin
            ei = 2'((3 + k) % 4);
            mem_ack_b = 1; mem_rdata = 32'h3333_0000 + k;
            step();
            tests++; if (refill_idx_b !== ei) begin fails++; $display("FAIL crit idx beat %0d: got %0d want %0d", k, refill_idx_b, ei); end
            tests++; if (refill_crit_b !== (k == 0)) begin fails++; $display("FAIL crit flag beat %0d: got %b want %b", k, refill_crit_b, (k == 0)); end
            tests++; if (refill_done_b !== (k == 3)) begin fails++; $display("FAIL crit done beat %0d: got %b want %b", k, refill_done_b, (k == 3)); end
            if (k < 3) begin
                tests++; if (mem_addr_b !== 32'h1230 + 4 * ((4 + k) % 4)) begin fails++; $display("FAIL crit mem_addr beat %0d: got %h want %h", k, mem_addr_b, 32'h1230 + 4 * ((4 + k) % 4)); end
            end
        end
        mem_ack_b = 0;
        step();
    endtask

    task automatic test_dirty();
        logic [1:0] ei;
        miss_addr = 32'h0000_1234; victim_addr = 32'h0000_8000; victim_dirty = 1; miss_valid_a = 1;
        step();
        miss_valid_a = 0; victim_dirty = 0;
        for (int k = 0; k < 4; k++) begin
            ei = 2'(k);
            tests++; if ({mem_req_a, mem_we_a} !== 2'b11) begin fails++; $display("FAIL wb req/we beat %0d: got %b want 11", k, {mem_req_a, mem_we_a}); end
            tests++; if (mem_addr_a !== 32'h8000 + 4 * k) begin fails++; $display("FAIL wb mem_addr beat %0d: got %h want %h", k, mem_addr_a, 32'h8000 + 4 * k); end
            tests++; if (victim_idx_a !== ei) begin fails++; $display("FAIL wb victim_idx beat %0d: got %0d want %0d", k, victim_idx_a, ei); end
            tests++; if (mem_wdata_a !== 32'hA0 + k) begin fails++; $display("FAIL wb wdata beat %0d: got %h want %h", k, mem_wdata_a, 32'hA0 + k); end
            tests++; if (refill_valid_a !== 1'b0) begin fails++; $display("FAIL wb refill_valid beat %0d: got %b want 0", k, refill_valid_a); end
            mem_ack_a = 1;
            step();
        end
        tests++; if ({mem_req_a, mem_we_a} !== 2'b10) begin fails++; $display("FAIL wb->refill req/we: got %b want 10", {mem_req_a, mem_we_a}); end
        tests++; if (mem_addr_a !== 32'h1230) begin fails++; $display("FAIL wb->refill mem_addr: got %h want 1230", mem_addr_a); end
        for (int k = 0; k < 4; k++) begin
            ei = 2'(k);
            mem_rdata = 32'h2222_0000 + k;
            step();
            tests++; if (refill_valid_a !== 1'b1 || refill_idx_a !== ei) begin fails++; $display("FAIL dirty refill beat %0d: got valid %b idx %0d want 1 %0d", k, refill_valid_a, refill_idx_a, ei); end
            tests++; if (refill_data_a !== 32'h2222_0000 + k) begin fails++; $display("FAIL dirty refill data %0d: got %h want %h", k, refill_data_a, 32'h2222_0000 + k); end
            tests++; if (refill_done_a !== (k == 3)) begin fails++; $display("FAIL dirty done beat %0d: got %b want %b", k, refill_done_a, (k == 3)); end
        end
        mem_ack_a = 0;
        step();
    endtask

    task automatic test_stall();
        logic [1:0] ei;
        int         beats;
        logic       ack_now;
        miss_addr = 32'h0000_1238; victim_dirty = 0; miss_valid_b = 1;
        step();
        miss_valid_b = 0;
        ei = 2'd2;
        beats = 0;
        for (int c = 1; c <= 20 && beats < 4; c++) begin
            ack_now = (c % 3 == 0);
            mem_ack_b = ack_now;
            mem_rdata = 32'h5000 + beats;
            miss_valid_b = (c == 4);
            miss_addr = (c == 4) ? 32'h0000_9990 : 32'h0000_1238;
            step();
            if (ack_now) begin
                tests++; if (refill_valid_b !== 1'b1 || refill_idx_b !== ei) begin fails++; $display("FAIL stall beat %0d: got valid %b idx %0d want 1 %0d", beats, refill_valid_b, refill_idx_b, ei); end
                tests++; if (refill_data_b !== 32'h5000 + beats) begin fails++; $display("FAIL stall data %0d: got %h want %h", beats, refill_data_b, 32'h5000 + beats); end
                tests++; if (refill_done_b !== (beats == 3)) begin fails++; $display("FAIL stall done %0d: got %b want %b", beats, refill_done_b, (beats == 3)); end
                ei = ei + 2'd1;
                beats++;
            end else begin
                tests++; if (refill_valid_b !== 1'b0) begin fails++; $display("FAIL stall idle valid cycle %0d: got %b want 0", c, refill_valid_b); end
                tests++; if ({mem_req_b, mem_we_b} !== 2'b10) begin fails++; $display("FAIL stall req/we cycle %0d: got %b want 10", c, {mem_req_b, mem_we_b}); end
                tests++; if (mem_addr_b !== 32'h1230 + 4 * ei) begin fails++; $display("FAIL stall mem_addr cycle %0d: got %h want %h", c, mem_addr_b, 32'h1230 + 4 * ei); end
            end
        end
        mem_ack_b = 0; miss_valid_b = 0;
        tests++; if (beats != 4) begin fails++; $display("FAIL stall beat count: got %0d want 4", beats); end
        step();
        tests++; if ({busy_b, mem_req_b, refill_valid_b} !== 3'b000) begin fails++; $display("FAIL stall mid-miss ignored: got busy/req/valid %b want 000", {busy_b, mem_req_b, refill_valid_b}); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] ei;
        miss_addr = 32'h0000_1234; victim_dirty = 0; miss_valid_a = 1;
        step();
        miss_valid_a = 0;
        mem_ack_a = 1;
        for (int k = 0; k < 2; k++) begin
            mem_rdata = 32'h7777_0000 + k;
            step();
        end
        tests++; if (refill_valid_a !== 1'b1 || refill_idx_a !== 2'd1) begin fails++; $display("FAIL pre-reset beat: got valid %b idx %0d want 1 1", refill_valid_a, refill_idx_a); end
        reset = 1'b0;
        #1;
        tests++; if ({mem_req_a, mem_we_a, refill_valid_a, busy_a} !== 4'b0000) begin fails++; $display("FAIL mid reset flags: got %b want 0000", {mem_req_a, mem_we_a, refill_valid_a, busy_a}); end
        tests++; if (mem_addr_a !== 32'h0 || refill_data_a !== 32'h0 || refill_idx_a !== 2'd0) begin fails++; $display("FAIL mid reset values: got addr %h data %h idx %0d want 0 0 0", mem_addr_a, refill_data_a, refill_idx_a); end
        step();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++; if ({refill_valid_a, refill_done_a, mem_req_a} !== 3'b000) begin fails++; $display("FAIL post reset idle ack %0d: got %b want 000", k, {refill_valid_a, refill_done_a, mem_req_a}); end
        end
        mem_ack_a = 0;
        miss_addr = 32'h0000_2000; miss_valid_a = 1;
        step();
        miss_valid_a = 0;
        tests++; if (mem_addr_a !== 32'h2000 || mem_req_a !== 1'b1) begin fails++; $display("FAIL restart start: got addr %h req %b want 2000 1", mem_addr_a, mem_req_a); end
        mem_ack_a = 1;
        for (int k = 0; k < 4; k++) begin
            ei = 2'(k);
            mem_rdata = 32'h8888_0000 + k;
            step();
            tests++; if (refill_idx_a !== ei || refill_data_a !== 32'h8888_0000 + k) begin fails++; $display("FAIL restart beat %0d: got idx %0d data %h want %0d %h", k, refill_idx_a, refill_data_a, ei, 32'h8888_0000 + k); end
            tests++; if (refill_crit_a !== (k == 0) || refill_done_a !== (k == 3)) begin fails++; $display("FAIL restart crit/done %0d: got %b%b want %b%b", k, refill_crit_a, refill_done_a, (k == 0), (k == 3)); end
        end
        mem_ack_a = 0;
        step();
    endtask

    task automatic test_line8();
        logic [2:0] ei;
        logic [2:0] en;
        miss_addr = 32'h0000_401C; victim_dirty = 0; miss_valid_c = 1;
        step();
        miss_valid_c = 0;
        tests++; if (mem_addr_c !== 32'h401C) begin fails++; $display("FAIL line8 start mem_addr: got %h want 401c", mem_addr_c); end
        mem_ack_c = 1;
        for (int k = 0; k < 8; k++) begin
            ei = 3'((7 + k) % 8);
            en = 3'((8 + k) % 8);
            mem_rdata = 32'h4444_0000 + k;
            step();
            tests++; if (refill_idx_c !== ei) begin fails++; $display("FAIL line8 idx beat %0d: got %0d want %0d", k, refill_idx_c, ei); end
            tests++; if (refill_crit_c !== (k == 0) || refill_done_c !== (k == 7)) begin fails++; $display("FAIL line8 crit/done %0d: got %b%b want %b%b", k, refill_crit_c, refill_done_c, (k == 0), (k == 7)); end
            if (k < 7) begin
                tests++; if (mem_addr_c !== 32'h4000 + 4 * en) begin fails++; $display("FAIL line8 mem_addr beat %0d: got %h want %h", k, mem_addr_c, 32'h4000 + 4 * en); end
            end
        end
        mem_ack_c = 0;
        step();
        tests++; if ({busy_c, mem_req_c} !== 2'b00) begin fails++; $display("FAIL line8 end busy/req: got %b want 00", {busy_c, mem_req_c}); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_clean_linear();
        test_clean_crit();
        test_dirty();
        test_stall();
        test_reset_mid();
        test_line8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
